// File: rtl/seq_divider.sv
// seq_divider: multi-cycle signed/unsigned restoring divider.
// Produces z = {remainder, quotient}; one quotient bit per clock, then a
// sign-fix cycle. Division by zero finishes in one cycle with a flag.
module seq_divider #(
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic               div_by_zero,
    output logic [2*WIDTH-1:0] z
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    // Two's-complement negation, applied only when en is set.
    function automatic logic [WIDTH-1:0] f_cond_neg(input logic [WIDTH-1:0] v, input logic en);
        logic [WIDTH-1:0] res;
        if (en) begin
            res = (~v) + WIDTH'(1);
        end else begin
            res = v;
        end
        return res;
    endfunction

    // Magnitude of an operand: negated only for negative signed values.
    // The most-negative value maps onto itself, which is correct as unsigned.
    function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] v, input logic sm);
        return f_cond_neg(v, sm & v[WIDTH-1]);
    endfunction

    state_t               state_q, state_d;
    logic [CW-1:0]        count_q, count_d;
    logic [WIDTH-1:0]     rem_q, rem_d;       // partial remainder
    logic [WIDTH-1:0]     quo_q, quo_d;       // dividend bits shifting out, quotient bits shifting in
    logic [WIDTH-1:0]     dvs_q, dvs_d;       // divisor magnitude
    logic                 neg_q_q, neg_q_d;   // quotient must be negated
    logic                 neg_r_q, neg_r_d;   // remainder must be negated
    logic [2*WIDTH-1:0]   z_q, z_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 dbz_q, dbz_d;

    logic [WIDTH:0]       shift_s;
    logic [WIDTH:0]       diff_s;
    logic                 a_neg_s;
    logic                 b_neg_s;

    // Trial subtraction: the MSB of the WIDTH+1-bit difference is the borrow,
    // i.e. the restore decision.
    assign shift_s = {rem_q, quo_q[WIDTH-1]};
    assign diff_s  = shift_s - {1'b0, dvs_q};
    assign a_neg_s = signed_mode & a[WIDTH-1];
    assign b_neg_s = signed_mode & b[WIDTH-1];

    // State register and datapath registers, cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= S_IDLE;
            count_q <= {CW{1'b0}};
            rem_q   <= {WIDTH{1'b0}};
            quo_q   <= {WIDTH{1'b0}};
            dvs_q   <= {WIDTH{1'b0}};
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            z_q     <= {(2*WIDTH){1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            neg_q_q <= neg_q_d;
            neg_r_q <= neg_r_d;
            z_q     <= z_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    // Next-state and datapath logic; done is a pulse so it defaults low.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        neg_q_d = neg_q_q;
        neg_r_d = neg_r_q;
        z_d     = z_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (b == {WIDTH{1'b0}}) begin
                        // Division by zero: result is ready next cycle, no iterations.
                        z_d     = {a, {WIDTH{1'b1}}};
                        done_d  = 1'b1;
                        dbz_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        rem_d   = {WIDTH{1'b0}};
                        quo_d   = f_mag(a, signed_mode);
                        dvs_d   = f_mag(b, signed_mode);
                        neg_q_d = a_neg_s ^ b_neg_s;
                        neg_r_d = a_neg_s;
                        count_d = {CW{1'b0}};
                        busy_d  = 1'b1;
                        state_d = S_ITER;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ITER: begin
                if (diff_s[WIDTH]) begin
                    rem_d = shift_s[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end else begin
                    rem_d = diff_s[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end
                count_d = count_q + CW'(1);
                if (count_q == CW'(WIDTH - 1)) begin
                    state_d = S_FIX;
                end else begin
                    state_d = S_ITER;
                end
            end
            S_FIX: begin
                z_d     = {f_cond_neg(rem_q, neg_r_q), f_cond_neg(quo_q, neg_q_q)};
                done_d  = 1'b1;
                dbz_d   = 1'b0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign z           = z_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed-vector bench for seq_divider (WIDTH = 32).
module tb_seq_divider;

    localparam int W = 32;

    logic           clk;
    logic           clr;
    logic           start;
    logic           signed_mode;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic           div_by_zero;
    logic [2*W-1:0] z;

    int n_vec  = 0;
    int n_miss = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .clr         (clr),
        .start       (start),
        .signed_mode (signed_mode),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .z           (z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge: present operands, let the next posedge sample them
    // (cycle 0), then drop start and scramble operands (must not be re-sampled).
    task automatic drive_start(input logic sm, input logic [W-1:0] av, input logic [W-1:0] bv);
        start       = 1'b1;
        signed_mode = sm;
        a           = av;
        b           = bv;
        @(posedge clk);
        #1;
        start       = 1'b0;
        signed_mode = ~sm;
        a           = 32'hA5A5_5A5A;
        b           = 32'h0000_0000;
    endtask

    // Walk cycles 1.. at negedges until done, checking busy each cycle.
    // Optionally pulses start (with other operands) in cycles 5 and 20.
    task automatic wait_done(input bit is_dbz, input bit poke, output int lat, output int busy_err);
        bit exp_busy;
        lat      = -1;
        busy_err = 0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            exp_busy = is_dbz ? 1'b0 : (cyc <= W + 1);
            if (busy !== exp_busy) busy_err++;
            if (done === 1'b1) begin
                lat = cyc;
                break;
            end
            if (poke && (cyc == 5 || cyc == 20)) begin
                start = 1'b1;
                a     = 32'd1000;
                b     = 32'd9;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic sm, input logic [W-1:0] av,
                          input logic [W-1:0] bv, input logic [63:0] exp_z,
                          input bit exp_dbz, input bit poke);
        int lat;
        int berr;
        drive_start(sm, av, bv);
        wait_done(exp_dbz, poke, lat, berr);
        chk({tag, " latency"}, 64'(lat), exp_dbz ? 64'd1 : 64'd34);
        chk({tag, " busy"}, 64'(berr), 64'd0);
        chk({tag, " z"}, z, exp_z);
        chk({tag, " dbz"}, {63'd0, div_by_zero}, {63'd0, exp_dbz});
    endtask

    initial begin
        int lat;
        int berr;
        int done_seen;
        clr         = 1'b0;
        start       = 1'b0;
        signed_mode = 1'b0;
        a           = 32'd0;
        b           = 32'd0;

        #23;
        chk("reset busy", {63'd0, busy}, 64'd0);
        chk("reset done", {63'd0, done}, 64'd0);
        chk("reset dbz",  {63'd0, div_by_zero}, 64'd0);
        chk("reset z", z, 64'd0);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);

        // Signed, all sign combinations.
        run_op("s 7/2",   1'b1, 32'd7,          32'd2,          {32'd1,          32'd3},          1'b0, 1'b0);
        run_op("s -7/2",  1'b1, 32'hFFFF_FFF9,  32'd2,          {32'hFFFF_FFFF,  32'hFFFF_FFFD},  1'b0, 1'b0);
        run_op("s 7/-2",  1'b1, 32'd7,          32'hFFFF_FFFE,  {32'd1,          32'hFFFF_FFFD},  1'b0, 1'b0);
        run_op("s -7/-2", 1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  {32'hFFFF_FFFF,  32'd3},          1'b0, 1'b0);

        // Unsigned vs signed interpretation of the same bits.
        run_op("u ffffffff/2", 1'b0, 32'hFFFF_FFFF, 32'd2, {32'd1, 32'h7FFF_FFFF}, 1'b0, 1'b0);
        run_op("s -1/2",       1'b1, 32'hFFFF_FFFF, 32'd2, {32'hFFFF_FFFF, 32'd0}, 1'b0, 1'b0);

        // Overflow: min / -1 wraps, no flag.
        run_op("s min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 1'b0, 1'b0);

        // Divide by zero, then a normal op clears the flag.
        @(negedge clk);
        run_op("dbz", 1'b0, 32'h0000_1234, 32'd0, {32'h0000_1234, 32'hFFFF_FFFF}, 1'b1, 1'b0);
        @(negedge clk);
        run_op("10/3 after dbz", 1'b0, 32'd10, 32'd3, {32'd1, 32'd3}, 1'b0, 1'b0);

        // Starts during busy are ignored.
        @(negedge clk);
        run_op("poke 100/7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0, 1'b1);

        // Back-to-back: start issued in the done cycle.
        run_op("b2b 50/6", 1'b0, 32'd50, 32'd6, {32'd2, 32'd8}, 1'b0, 1'b0);

        // Reset mid-operation.
        @(negedge clk);
        drive_start(1'b0, 32'd1000, 32'd3);
        for (int cyc = 1; cyc <= 10; cyc++) @(negedge clk);
        chk("pre-reset busy", {63'd0, busy}, 64'd1);
        #2;
        clr = 1'b0;
        #1;
        chk("abort busy", {63'd0, busy}, 64'd0);
        chk("abort done", {63'd0, done}, 64'd0);
        chk("abort z", z, 64'd0);
        @(negedge clk);
        clr = 1'b1;
        done_seen = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) done_seen++;
        end
        chk("no done after abort", 64'(done_seen), 64'd0);
        run_op("post-reset 100/7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
